// File: rtl/vga_timing_pmod_if.sv
// Pixel-timing bus between the VGA timing generator and downstream pattern logic.
// The generator side is master: it takes run enable and pixel colour, and drives timing and the PMOD byte.
interface vga_timing_pmod_if #(
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned FRAME_W = 8
);
  logic               en;
  logic [5:0]         rgb;
  logic               pix_en;
  logic [CNT_W-1:0]   hpos;
  logic [CNT_W-1:0]   vpos;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;
  logic [7:0]         vga_pmod;

  modport master (
    input  en, rgb,
    output pix_en, hpos, vpos, display_on, line_start, frame_start,
           frame_count, vga_pmod
  );

  modport slave (
    output en, rgb,
    input  pix_en, hpos, vpos, display_on, line_start, frame_start,
           frame_count, vga_pmod
  );
endinterface

// File: rtl/vga_timing_pmod.sv
// Parametrised VGA timing generator with a registered, blanked TinyVGA PMOD output stage.
// Counters advance on pixel ticks from a clock divider; the PMOD byte lags the counters by one tick.
module vga_timing_pmod #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_pmod_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Window bounds are one bit wider so a sync or active region ending exactly at 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0] H_VIS  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_VIS  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [7:0] PMOD_RST = {~HSYNC_POL, 3'b000, ~VSYNC_POL, 3'b000};

  logic [DIV_W-1:0]   div_q,   div_d;
  logic [CNT_W-1:0]   hpos_q,  hpos_d;
  logic [CNT_W-1:0]   vpos_q,  vpos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         pmod_q,  pmod_d;

  logic             pix_en;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W:0]   hpos_ext;
  logic [CNT_W:0]   vpos_ext;
  logic             display_on;
  logic             hsync_act;
  logic             vsync_act;
  logic             hsync;
  logic             vsync;
  logic [5:0]       rgb_m;

  always_comb begin
    pix_en     = bus.en && (div_q == DIV_LAST);
    h_wrap     = (hpos_q == H_LAST);
    v_wrap     = (vpos_q == V_LAST);
    hpos_ext   = {1'b0, hpos_q};
    vpos_ext   = {1'b0, vpos_q};
    display_on = (hpos_ext < H_VIS) && (vpos_ext < V_VIS);
    hsync_act  = (hpos_ext >= HS_BEG) && (hpos_ext < HS_END);
    vsync_act  = (vpos_ext >= VS_BEG) && (vpos_ext < VS_END);
    hsync      = hsync_act ? HSYNC_POL : ~HSYNC_POL;
    vsync      = vsync_act ? VSYNC_POL : ~VSYNC_POL;
    rgb_m      = display_on ? bus.rgb : '0;
  end

  always_comb begin
    div_d   = div_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    pmod_d  = pmod_q;
    if (bus.en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
    if (pix_en) begin
      hpos_d = h_wrap ? '0 : hpos_q + CNT_W'(1);
      if (h_wrap) begin
        vpos_d = v_wrap ? '0 : vpos_q + CNT_W'(1);
        if (v_wrap) begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end
      // PMOD bit order is {hsync,B0,G0,R0,vsync,B1,G1,R1}; rgb is {R1,R0,G1,G0,B1,B0}.
      pmod_d = {hsync, rgb_m[0], rgb_m[2], rgb_m[4],
                vsync, rgb_m[1], rgb_m[3], rgb_m[5]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
      pmod_q  <= PMOD_RST;
    end else begin
      div_q   <= div_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
      pmod_q  <= pmod_d;
    end
  end

  assign bus.pix_en      = pix_en;
  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.display_on  = display_on;
  assign bus.line_start  = pix_en && (hpos_q == '0);
  assign bus.frame_start = pix_en && (hpos_q == '0) && (vpos_q == '0);
  assign bus.frame_count = frame_q;
  assign bus.vga_pmod    = pmod_q;

endmodule

// File: tb/tb_vga_timing_pmod.sv
// Bench for vga_timing_pmod: four instances (default 640x480, tiny with divide-by-3,
// 800x600 positive syncs, tiny positive syncs) checked every cycle against a tick-count model.
module tb_vga_timing_pmod;

  logic clk;
  logic       rst_v [4];
  logic       en_v  [4];
  logic [5:0] rgb_v [4];
  bit         check_on;

  int n_total;
  int n_pass;

  localparam longint HT  [4] = '{800, 15, 1056, 15};
  localparam longint VT  [4] = '{525, 8, 628, 8};
  localparam longint HA  [4] = '{640, 8, 800, 8};
  localparam longint VA  [4] = '{480, 4, 600, 4};
  localparam longint HSB [4] = '{656, 10, 840, 10};
  localparam longint HSE [4] = '{752, 13, 968, 13};
  localparam longint VSB [4] = '{490, 5, 601, 5};
  localparam longint VSE [4] = '{492, 7, 605, 7};
  localparam bit     HP  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit     VP  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam longint DIV [4] = '{1, 3, 1, 1};
  localparam longint FW  [4] = '{8, 2, 8, 2};
  localparam logic [5:0] PAT [8] = '{6'h3F, 6'h15, 6'h2A, 6'h01, 6'h20, 6'h0C, 6'h33, 6'h00};

  vga_timing_pmod_if #(.CNT_W(11), .FRAME_W(8)) b0 ();
  vga_timing_pmod_if #(.CNT_W(11), .FRAME_W(2)) b1 ();
  vga_timing_pmod_if #(.CNT_W(11), .FRAME_W(8)) b2 ();
  vga_timing_pmod_if #(.CNT_W(11), .FRAME_W(2)) b3 ();

  vga_timing_pmod u0 (.clk(clk), .rst(rst_v[0]), .bus(b0));

  vga_timing_pmod #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(3), .CNT_W(11), .FRAME_W(2)
  ) u1 (.clk(clk), .rst(rst_v[1]), .bus(b1));

  vga_timing_pmod #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .CNT_W(11), .FRAME_W(8)
  ) u2 (.clk(clk), .rst(rst_v[2]), .bus(b2));

  vga_timing_pmod #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .CNT_W(11), .FRAME_W(2)
  ) u3 (.clk(clk), .rst(rst_v[3]), .bus(b3));

  assign b0.en = en_v[0];  assign b0.rgb = rgb_v[0];
  assign b1.en = en_v[1];  assign b1.rgb = rgb_v[1];
  assign b2.en = en_v[2];  assign b2.rgb = rgb_v[2];
  assign b3.en = en_v[3];  assign b3.rgb = rgb_v[3];

  logic        pe_a [4];
  logic [10:0] hp_a [4];
  logic [10:0] vp_a [4];
  logic        do_a [4];
  logic        ls_a [4];
  logic        fs_a [4];
  logic [7:0]  fc_a [4];
  logic [7:0]  pm_a [4];

  assign pe_a[0] = b0.pix_en;  assign hp_a[0] = b0.hpos;  assign vp_a[0] = b0.vpos;
  assign do_a[0] = b0.display_on;  assign ls_a[0] = b0.line_start;  assign fs_a[0] = b0.frame_start;
  assign fc_a[0] = b0.frame_count;  assign pm_a[0] = b0.vga_pmod;
  assign pe_a[1] = b1.pix_en;  assign hp_a[1] = b1.hpos;  assign vp_a[1] = b1.vpos;
  assign do_a[1] = b1.display_on;  assign ls_a[1] = b1.line_start;  assign fs_a[1] = b1.frame_start;
  assign fc_a[1] = {6'b0, b1.frame_count};  assign pm_a[1] = b1.vga_pmod;
  assign pe_a[2] = b2.pix_en;  assign hp_a[2] = b2.hpos;  assign vp_a[2] = b2.vpos;
  assign do_a[2] = b2.display_on;  assign ls_a[2] = b2.line_start;  assign fs_a[2] = b2.frame_start;
  assign fc_a[2] = b2.frame_count;  assign pm_a[2] = b2.vga_pmod;
  assign pe_a[3] = b3.pix_en;  assign hp_a[3] = b3.hpos;  assign vp_a[3] = b3.vpos;
  assign do_a[3] = b3.display_on;  assign ls_a[3] = b3.line_start;  assign fs_a[3] = b3.frame_start;
  assign fc_a[3] = {6'b0, b3.frame_count};  assign pm_a[3] = b3.vga_pmod;

  // Model state: enabled clocks since reset, pixel ticks taken, and the last tick's position and colour.
  longint     n_clk   [4];
  longint     ticks   [4];
  longint     last_t  [4];
  logic [5:0] last_rgb[4];
  bit         have    [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] enc(input int i, input longint t, input logic [5:0] c_in);
    longint h = t % HT[i];
    longint v = (t / HT[i]) % VT[i];
    logic hs, vs;
    logic [5:0] c;
    hs = (h >= HSB[i] && h < HSE[i]) ? HP[i] : !HP[i];
    vs = (v >= VSB[i] && v < VSE[i]) ? VP[i] : !VP[i];
    c  = (h < HA[i] && v < VA[i]) ? c_in : 6'd0;
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  function automatic logic [41:0] model_out(input int i);
    longint t = ticks[i];
    longint h = t % HT[i];
    longint v = (t / HT[i]) % VT[i];
    longint f = (t / (HT[i] * VT[i])) % (longint'(1) << FW[i]);
    logic pe, disp;
    logic [7:0] pm;
    pe   = en_v[i] && ((n_clk[i] % DIV[i]) == DIV[i] - 1);
    disp = (h < HA[i]) && (v < VA[i]);
    pm   = have[i] ? enc(i, last_t[i], last_rgb[i]) : {!HP[i], 3'b000, !VP[i], 3'b000};
    return {pe, h[10:0], v[10:0], disp, pe && (h == 0), pe && (h == 0) && (v == 0), f[7:0], pm};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      n_clk[i] = 0; ticks[i] = 0; last_t[i] = 0; last_rgb[i] = '0; have[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rst_v[i]) begin
          n_clk[i] = 0; ticks[i] = 0; have[i] = 1'b0;
        end else if (en_v[i]) begin
          if ((n_clk[i] % DIV[i]) == DIV[i] - 1) begin
            last_t[i]   = ticks[i];
            last_rgb[i] = rgb_v[i];
            have[i]     = 1'b1;
            ticks[i]++;
          end
          n_clk[i]++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_on) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("u%0d_outputs", i),
              {22'd0, pe_a[i], hp_a[i], vp_a[i], do_a[i], ls_a[i], fs_a[i], fc_a[i], pm_a[i]},
              {22'd0, model_out(i)});
        end
      end
    end
  end

  initial begin
    int cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 1; i < 4; i++) rgb_v[i] = PAT[(cyc + i) % 8];
      cyc++;
    end
  end

  initial begin
    int hs_cnt = 0, hs_first = -1, hs_last = -1;
    int line_k [2];
    int nl = 0;
    logic [7:0] pm640 = '0, pm641 = '0;
    int pe_cnt = 0, fs_cnt = 0, viol = 0, vs_cnt = 0;
    int u2_hs = 0, u2_first = -1;
    logic [7:0] prev_pm;
    logic prev_pe;
    bit found;

    check_on = 1'b0;
    line_k[0] = 0;
    line_k[1] = 0;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1; en_v[i] = 1'b1; rgb_v[i] = 6'h00;
    end
    rgb_v[0] = 6'h3F;

    repeat (2) @(negedge clk);
    check_on = 1'b1;
    chk("rst_pmod_u0", {56'd0, pm_a[0]}, 64'h88);
    chk("rst_pmod_u2", {56'd0, pm_a[2]}, 64'h00);
    chk("rst_hpos_u0", {53'd0, hp_a[0]}, 64'd0);
    chk("rst_frame_start_u0", {63'd0, fs_a[0]}, 64'd1);
    chk("rst_pix_en_u1", {63'd0, pe_a[1]}, 64'd0);
    prev_pm = pm_a[1];
    prev_pe = pe_a[1];
    #2;
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (vp_a[0] == 11'd0 && pm_a[0][7] == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hp_a[0]);
        hs_last = int'(hp_a[0]);
      end
      if (ls_a[0] && nl < 2) begin
        line_k[nl] = c;
        nl++;
      end
      if (vp_a[0] == 11'd0 && hp_a[0] == 11'd640) pm640 = pm_a[0];
      if (vp_a[0] == 11'd0 && hp_a[0] == 11'd641) pm641 = pm_a[0];
      if (c < 300 && pe_a[1]) pe_cnt++;
      if (c == 299)  chk("u1_hpos_after_300clk", {53'd0, hp_a[1]}, 64'd10);
      if (c == 1438) chk("u1_frame_count_3", {56'd0, fc_a[1]}, 64'd3);
      if (c == 1439) chk("u1_frame_count_wrap", {56'd0, fc_a[1]}, 64'd0);
      if (fs_a[1]) fs_cnt++;
      if (pm_a[1] !== prev_pm && !prev_pe) viol++;
      prev_pm = pm_a[1];
      prev_pe = pe_a[1];
      if (c < 120 && pm_a[3][3]) vs_cnt++;
      if (vp_a[2] == 11'd0 && pm_a[2][7]) begin
        u2_hs++;
        if (u2_first < 0) u2_first = int'(hp_a[2]);
      end
    end

    chk("u0_hsync_low_ticks", 64'(hs_cnt), 64'd96);
    chk("u0_hsync_first_hpos", 64'(hs_first), 64'd657);
    chk("u0_hsync_last_hpos", 64'(hs_last), 64'd752);
    chk("u0_line_period", 64'(line_k[1] - line_k[0]), 64'd800);
    chk("u0_pmod_after_639", {56'd0, pm640}, 64'hFF);
    chk("u0_pmod_after_640", {56'd0, pm641}, 64'h88);
    chk("u1_pix_en_per_300clk", 64'(pe_cnt), 64'd100);
    chk("u1_frame_start_count", 64'(fs_cnt), 64'd6);
    chk("u1_pmod_change_off_tick", 64'(viol), 64'd0);
    chk("u3_vsync_high_ticks", 64'(vs_cnt), 64'd30);
    chk("u2_hsync_high_ticks", 64'(u2_hs), 64'd128);
    chk("u2_hsync_first_hpos", 64'(u2_first), 64'd841);

    // Reset while u1 sits inside both hsync and vsync.
    found = 1'b0;
    for (int w = 0; w < 1000 && !found; w++) begin
      @(negedge clk);
      if (hp_a[1] == 11'd11 && vp_a[1] == 11'd5) found = 1'b1;
    end
    chk("wait_u1_in_sync", {63'd0, found}, 64'd1);
    chk("u1_pmod_in_sync", {56'd0, pm_a[1]}, 64'h00);
    #2 rst_v[1] = 1'b1;
    @(negedge clk);
    chk("u1_rst_hpos", {53'd0, hp_a[1]}, 64'd0);
    chk("u1_rst_vpos", {53'd0, vp_a[1]}, 64'd0);
    chk("u1_rst_pmod", {56'd0, pm_a[1]}, 64'h88);
    chk("u1_rst_frame", {56'd0, fc_a[1]}, 64'd0);
    #2 rst_v[1] = 1'b0;

    // Pause u0 mid-hsync for five clocks.
    found = 1'b0;
    for (int w = 0; w < 1000 && !found; w++) begin
      @(negedge clk);
      if (hp_a[0] == 11'd700) found = 1'b1;
    end
    chk("wait_u0_hpos700", {63'd0, found}, 64'd1);
    #2 en_v[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("u0_hold_hpos", {53'd0, hp_a[0]}, 64'd700);
      chk("u0_hold_pmod", {56'd0, pm_a[0]}, 64'h08);
      chk("u0_hold_no_pix_en", {63'd0, pe_a[0]}, 64'd0);
    end
    #2 en_v[0] = 1'b1;
    @(negedge clk);
    chk("u0_resume_hpos", {53'd0, hp_a[0]}, 64'd701);

    // Reset wins over a low enable.
    #2;
    en_v[3]  = 1'b0;
    rst_v[3] = 1'b1;
    @(negedge clk);
    chk("u3_rst_hpos", {53'd0, hp_a[3]}, 64'd0);
    chk("u3_rst_vpos", {53'd0, vp_a[3]}, 64'd0);
    chk("u3_rst_pmod", {56'd0, pm_a[3]}, 64'h00);
    chk("u3_rst_no_pix_en", {63'd0, pe_a[3]}, 64'd0);
    #2;
    rst_v[3] = 1'b0;
    en_v[3]  = 1'b1;

    repeat (50) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
